// File: rtl/modbus_rtu_rx_framer_if.sv
// Bus bundle between the UART receiver / frame consumer and the Modbus RTU
// receive framer.
//   rx_valid/rx_data/rx_err : byte strobe, byte, and error strobe from the UART
//   frame_valid/frame_len/crc_ok : the held frame and its CRC result
//   frame_ack              : consumer releases the held frame
//   rd_addr/rd_data        : buffer read port (1-cycle latency)
//   frame_drop/busy        : discard pulse, receive-in-progress level
// master = UART + consumer side, slave = the framer.
interface modbus_rtu_rx_framer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_err;
  logic              frame_valid;
  logic [ADDR_W:0]   frame_len;
  logic              crc_ok;
  logic              frame_ack;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              frame_drop;
  logic              busy;

  modport master (
    output rx_valid, rx_data, rx_err, frame_ack, rd_addr,
    input  frame_valid, frame_len, crc_ok, rd_data, frame_drop, busy
  );

  modport slave (
    input  rx_valid, rx_data, rx_err, frame_ack, rd_addr,
    output frame_valid, frame_len, crc_ok, rd_data, frame_drop, busy
  );
endinterface

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer. Delimits frames on the UART byte stream by
// inter-character silence (t1.5 ends the frame body, t3.5 ends the frame),
// buffers the bytes, runs CRC-16/Modbus over every stored byte and hands the
// finished frame to the consumer via frame_valid/frame_ack and a read port.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of modbus_rtu_rx_framer_if (see interface header)
module modbus_rtu_rx_framer #(
  parameter int unsigned T15_CYC = 85938,
  parameter int unsigned T35_CYC = 200521,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  modbus_rtu_rx_framer_if.slave  bus
);

  localparam int unsigned MAX_LEN = 1 << ADDR_W;
  localparam int unsigned LW      = ADDR_W + 1;
  localparam int unsigned GW      = $clog2(T35_CYC + 1);

  localparam logic [GW-1:0] GAP_T15 = GW'(T15_CYC);
  localparam logic [GW-1:0] GAP_T35 = GW'(T35_CYC);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_MIN = LW'(4);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_RECV   = 3'd2;
  localparam logic [2:0] ST_WAIT35 = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]        r_state;
  logic [GW-1:0]     r_gap;
  logic [LW-1:0]     r_len;
  logic [15:0]       r_crc;
  logic              r_err;
  logic              r_lost;
  logic              r_valid;
  logic              r_crc_ok;
  logic              r_drop;
  logic [LW-1:0]     r_frame_len;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_buf [MAX_LEN];

  logic              w_event;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [15:0]       w_crc_next;

  // One byte of CRC-16/Modbus (reflected 0xA001), unrolled into one cycle.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int unsigned i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  assign w_event    = bus.rx_valid | bus.rx_err;
  // First byte of a frame seeds from 0xFFFF instead of the stale register.
  assign w_crc_next = crc16_byte((r_state == ST_IDLE) ? 16'hFFFF : r_crc,
                                 bus.rx_data);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_len[ADDR_W-1:0];
    if (bus.rx_valid) begin
      if (r_state == ST_IDLE) begin
        w_wr_en   = 1'b1;
        w_wr_addr = '0;
      end else if (r_state == ST_RECV && r_len != LEN_MAX) begin
        w_wr_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_buf[w_wr_addr] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_gap       <= '0;
      r_len       <= '0;
      r_crc       <= '0;
      r_err       <= 1'b0;
      r_lost      <= 1'b0;
      r_valid     <= 1'b0;
      r_crc_ok    <= 1'b0;
      r_drop      <= 1'b0;
      r_frame_len <= '0;
      r_rd_data   <= '0;
    end else begin
      r_drop    <= 1'b0;
      r_rd_data <= r_buf[bus.rd_addr];

      if (w_event)               r_gap <= '0;
      else if (r_gap != GAP_T35) r_gap <= r_gap + GW'(1);

      // Threshold checks are gated by !w_event: a byte landing on the
      // threshold cycle restarts the gap and wins over the transition.
      case (r_state)
        ST_INIT: begin
          if (!w_event && r_gap == GAP_T35) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.rx_valid) begin
            r_len   <= LW'(1);
            r_crc   <= w_crc_next;
            r_err   <= 1'b0;
            r_state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (bus.rx_valid) begin
            if (r_len == LEN_MAX) begin
              r_err <= 1'b1;
            end else begin
              r_len <= r_len + LW'(1);
              r_crc <= w_crc_next;
            end
          end
          if (bus.rx_err) r_err <= 1'b1;
          if (!w_event && r_gap == GAP_T15) r_state <= ST_WAIT35;
        end
        ST_WAIT35: begin
          if (w_event) begin
            r_err <= 1'b1;
          end else if (r_gap == GAP_T35) begin
            if (!r_err && r_len >= LEN_MIN) begin
              r_frame_len <= r_len;
              r_crc_ok    <= (r_crc == 16'h0000);
              r_valid     <= 1'b1;
              r_lost      <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_drop  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          if (w_event) r_lost <= 1'b1;
          if (bus.frame_ack) begin
            r_valid <= 1'b0;
            // A byte on the ack cycle itself also counts as lost.
            if (r_lost || w_event) begin
              r_drop  <= 1'b1;
              r_state <= ST_INIT;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign bus.frame_valid = r_valid;
  assign bus.frame_len   = r_frame_len;
  assign bus.crc_ok      = r_crc_ok;
  assign bus.rd_data     = r_rd_data;
  assign bus.frame_drop  = r_drop;
  assign bus.busy        = (r_state == ST_RECV) || (r_state == ST_WAIT35);

endmodule

// File: doc/modbus_rtu_rx_framer.md
Name: modbus_rtu_rx_framer

Overview:
- Receive-side Modbus RTU framer. Consumes the byte stream from the UART receiver and delimits frames by inter-character silence (t1.5 / t3.5).
- Buffers each frame and checks CRC-16 (Modbus).
- Presents the finished frame to the protocol handler through a read port plus a valid/ack handshake.
- Runs in the system clock domain. Its rst_n is driven by the system reset generator's rst_n_o.

Parameters:
- T15_CYC, 85938: clk cycles equal to t1.5 (9600 baud at 50 MHz).
- T35_CYC, 200521: clk cycles equal to t3.5. Must be greater than T15_CYC.
- ADDR_W, 8: buffer address width. Buffer depth is MAX_LEN = 2**ADDR_W = 256 bytes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- rx_err  in  1  one-cycle strobe: UART parity or framing error.
- frame_valid  out  1  level; a frame is held in the buffer.
- frame_len  out  ADDR_W+1  byte count of the held frame, CRC bytes included.
- crc_ok  out  1  CRC residue of the held frame is 0x0000.
- frame_ack  in  1  one-cycle strobe from the consumer: buffer released.
- rd_addr  in  ADDR_W  buffer read address.
- rd_data  out  8  registered buffer read data, 1-cycle latency.
- frame_drop  out  1  one-cycle pulse: a frame was discarded.
- busy  out  1  high in RECV or WAIT35.

Behaviour:
- Reset and clocking: single clock clk. Reset is asynchronous and active-low (rst_n). Asserting rst_n low at any time, including mid-frame, does the following:
  - state goes to INIT;
  - all counters are cleared;
  - frame_valid, crc_ok, frame_drop and busy go to 0;
  - frame_len and rd_data go to 0.
  - Buffer contents are don't-care.
- Gap counter gap_cnt:
  - cleared to 0 in any cycle with rx_valid or rx_err;
  - otherwise increments, saturating at T35_CYC;
  - width is clog2(T35_CYC+1).
- CRC: Modbus CRC-16, reflected polynomial 0xA001, init 0xFFFF.
  - Updated by one byte per rx_valid, fully unrolled in a single cycle.
  - Covers every stored byte, CRC bytes included. A residue of 0x0000 means crc_ok = 1.
- States:
  - INIT: wait for silence. Any rx_valid or rx_err restarts the gap. At gap_cnt == T35_CYC, go to IDLE.
  - IDLE: on rx_valid, do all of the following and go to RECV:
    - write the byte to addr 0;
    - set len = 1, crc = update(0xFFFF, byte), err = 0.
    - An rx_err in IDLE is ignored.
  - RECV: on rx_valid, store at addr len, increment len and update crc.
    - If len is already MAX_LEN, the byte is not stored and err = 1.
    - rx_err sets err = 1.
    - At gap_cnt == T15_CYC, go to WAIT35.
  - WAIT35: rx_valid or rx_err sets err = 1 (t1.5 violation). The byte is not stored and the gap restarts.
    - At gap_cnt == T35_CYC, go to one of:
      - if err == 0 and len >= 4: go to DONE. frame_len = len, crc_ok = (crc == 0), frame_valid = 1, all registered in the same cycle.
      - else: pulse frame_drop for one cycle and go to IDLE.
- DONE:
  - frame_valid stays high, and frame_len/crc_ok are stable, until frame_ack.
  - Any rx_valid or rx_err sets a lost flag. The byte is discarded and the gap counter keeps running.
  - On frame_ack: frame_valid goes to 0 next cycle.
    - If lost == 1: pulse frame_drop and go to INIT.
    - If lost == 0: go to IDLE.
  - frame_ack outside DONE is ignored.
- A frame with crc_ok = 0 is still delivered. The consumer decides what to do with it.
- Read port: rd_data <= buf[rd_addr] every cycle, valid in any state. Contents are only guaranteed while frame_valid = 1.
- Simultaneous events: rx_valid in the same cycle as gap_cnt reaching a threshold takes priority. The gap restarts and the threshold transition does not fire.

Test Plan:
(Bench uses T15_CYC=15, T35_CYC=35.)
1. Reset, then 40 idle cycles, then bytes 01 03 00 00 00 01 84 0A spaced 5 cycles apart, then silence.
   -> frame_valid rises 36 cycles after the last byte; frame_len=8, crc_ok=1; rd_addr 0..7 returns the bytes with 1-cycle latency. frame_ack -> frame_valid=0, busy=0.
2. Same frame with the last byte 0x0B.
   -> frame_valid=1, crc_ok=0, frame_len=8.
3. Frame bytes, then a 20-cycle gap, then one more byte, then silence.
   -> no frame_valid; frame_drop pulses once, T35_CYC cycles after the late byte; next valid frame is accepted.
4. Frames too short or too long:
   - 3-byte frame -> frame_drop.
   - 260 bytes at 5-cycle spacing -> frame_drop; rx_err mid-frame -> frame_drop.
5. Frame held (no ack), then a byte arrives; then frame_ack.
   -> frame_drop pulse, state INIT; a byte 10 cycles after the ack is ignored; after 35 silent cycles the next frame is received.
6. rst_n low for 1 cycle mid-RECV.
   -> all outputs 0 immediately; bytes in the next 34 cycles are ignored (INIT); a subsequent frame is received normally.
